// File: rtl/ifu_fetch_if.sv
// Instruction-fetch bus bundle: memory request/response channel plus the
// fetched-instruction handshake towards decode.
interface ifu_fetch_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [PC_WIDTH-1:0]   imem_req_addr;
  logic                  imem_resp_valid;
  logic [INST_WIDTH-1:0] imem_resp_data;
  logic                  imem_resp_err;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [PC_WIDTH-1:0]   inst_pc;
  logic                  inst_err;

  // Fetch-stage side
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
  );

  // Memory/decode side
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one memory read per PC, registered instruction to
// decode, PC-advance control, and drop of a read made stale by a redirect.
module ifu_fetch #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                flush,
  output logic                pc_enable,
  ifu_fetch_if.master         bus
);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  kill_q, kill_d;
  logic                  capture;
  logic [PC_WIDTH-1:0]   req_addr_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic [PC_WIDTH-1:0]   inst_pc_q;
  logic                  inst_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CAPTURE;
      kill_q     <= 1'b0;
      req_addr_q <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      // A flushed CAPTURE samples a stale PC, but the FSM stays in CAPTURE
      // and resamples the redirected PC on the following cycle.
      if (state_q == CAPTURE) req_addr_q <= pc;
      if (capture) begin
        inst_q     <= bus.imem_resp_data;
        inst_err_q <= bus.imem_resp_err;
        inst_pc_q  <= req_addr_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    capture = 1'b0;
    case (state_q)
      CAPTURE: state_d = flush ? CAPTURE : REQ;
      REQ: begin
        // Request is never withdrawn; its response is dropped later instead.
        if (flush) kill_d = 1'b1;
        if (bus.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = CAPTURE;
          end else if (flush) begin
            state_d = CAPTURE;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      HOLD: if (flush || bus.inst_ready) state_d = CAPTURE;
      default: state_d = CAPTURE;
    endcase
  end

  assign pc_enable          = flush | ((state_q == HOLD) & bus.inst_ready);
  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = req_addr_q;
  assign bus.inst_valid     = (state_q == HOLD);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_err       = inst_err_q;

  a_valid_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_req_valid && bus.inst_valid));

  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.imem_req_valid && !bus.imem_req_ready) |=>
      (bus.imem_req_valid && $stable(bus.imem_req_addr)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a PC-generator model and a
// variable-latency instruction memory model.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        pc_enable;
  logic [31:0] target;
  logic [31:0] err_addr;
  int unsigned resp_lat;
  int          n_checks;
  int          n_fail;

  logic        mem_pend;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;

  ifu_fetch_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

  ifu_fetch #(.PC_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .flush     (flush),
    .pc_enable (pc_enable),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC generator: advances by 4 or loads the redirect target
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'h8000_0000;
    else if (pc_enable) pc <= flush ? target : pc + 32'd4;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], 16'h0013};
  endfunction

  // Memory: response resp_lat cycles after the accepting cycle
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_pend            <= 1'b0;
      mem_cnt             <= 0;
      mem_addr            <= '0;
      bus.imem_resp_valid <= 1'b0;
      bus.imem_resp_data  <= '0;
      bus.imem_resp_err   <= 1'b0;
    end else begin
      bus.imem_resp_valid <= 1'b0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (resp_lat <= 1) begin
          bus.imem_resp_valid <= 1'b1;
          bus.imem_resp_data  <= mem_data(bus.imem_req_addr);
          bus.imem_resp_err   <= (bus.imem_req_addr == err_addr);
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= resp_lat - 1;
          mem_addr <= bus.imem_req_addr;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 1) begin
          mem_pend            <= 1'b0;
          bus.imem_resp_valid <= 1'b1;
          bus.imem_resp_data  <= mem_data(mem_addr);
          bus.imem_resp_err   <= (mem_addr == err_addr);
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_hold(input string tag, input logic [31:0] i, input logic [31:0] ipc,
                            input logic ierr);
    check({tag, "_valid"}, {63'd0, bus.inst_valid}, 64'd1);
    check({tag, "_inst"}, {32'd0, bus.inst}, {32'd0, i});
    check({tag, "_pc"}, {32'd0, bus.inst_pc}, {32'd0, ipc});
    check({tag, "_err"}, {63'd0, bus.inst_err}, {63'd0, ierr});
  endtask

  task automatic check_req(input string tag, input logic [31:0] a);
    check({tag, "_rv"}, {63'd0, bus.imem_req_valid}, 64'd1);
    check({tag, "_addr"}, {32'd0, bus.imem_req_addr}, {32'd0, a});
    check({tag, "_iv"}, {63'd0, bus.inst_valid}, 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rv"}, {63'd0, bus.imem_req_valid}, 64'd0);
    check({tag, "_iv"}, {63'd0, bus.inst_valid}, 64'd0);
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    rst                = 1'b0;
    flush              = 1'b0;
    target             = '0;
    err_addr           = 32'h8000_0008;
    resp_lat           = 1;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b0;

    // Reset state
    step(); #1;
    check_idle("rst");
    check("rst_pce", {63'd0, pc_enable}, 64'd0);
    check("rst_inst", {32'd0, bus.inst}, 64'd0);
    check("rst_ipc", {32'd0, bus.inst_pc}, 64'd0);
    check("rst_ierr", {63'd0, bus.inst_err}, 64'd0);

    // Test 1: nominal zero-wait fetch, cycle 0 = CAPTURE
    step(); rst = 1'b1; #1;
    check_idle("t1_c0");
    step(); #1;
    check_req("t1_c1", 32'h8000_0000);
    step(); #1;
    check_idle("t1_c2");
    step(); #1;
    check_hold("t1_c3", 32'h0000_0413, 32'h8000_0000, 1'b0);

    // Test 2: decode stall for 5 cycles
    for (int unsigned i = 0; i < 5; i++) begin
      check_hold("t2_stall", 32'h0000_0413, 32'h8000_0000, 1'b0);
      check("t2_pce_stall", {63'd0, pc_enable}, 64'd0);
      step(); #1;
    end
    bus.inst_ready = 1'b1; #1;
    check("t2_pce_acc", {63'd0, pc_enable}, 64'd1);
    check("t2_iv_acc", {63'd0, bus.inst_valid}, 64'd1);

    // Test 3: memory back-pressure for 3 cycles
    step(); bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b0; #1;
    check_idle("t3_cap");
    check("t3_pce_cap", {63'd0, pc_enable}, 64'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(); #1;
      check_req("t3_bp", 32'h8000_0004);
    end
    step(); bus.imem_req_ready = 1'b1; #1;
    check_req("t3_acc", 32'h8000_0004);
    step(); #1;
    step(); #1;
    check_hold("t3_hold", 32'h0004_0013, 32'h8000_0004, 1'b0);
    bus.inst_ready = 1'b1;

    // Test 6a: access fault
    step(); bus.inst_ready = 1'b0; #1;
    step(); #1;
    check_req("t6_req", 32'h8000_0008);
    step(); #1;
    step(); #1;
    check_hold("t6_err", 32'h0008_0013, 32'h8000_0008, 1'b1);
    bus.inst_ready = 1'b1;

    // Test 4: flush in WAIT, stale response two cycles later
    step(); bus.inst_ready = 1'b0; resp_lat = 3; #1;
    step(); #1;
    check_req("t4_req", 32'h8000_000c);
    step(); flush = 1'b1; target = 32'h8000_0100; #1;
    check("t4_pce", {63'd0, pc_enable}, 64'd1);
    step(); flush = 1'b0; #1;
    check_idle("t4_w1");
    check("t4_pce_w1", {63'd0, pc_enable}, 64'd0);
    step(); #1;
    check("t4_resp", {63'd0, bus.imem_resp_valid}, 64'd1);
    check_idle("t4_drop");
    step(); #1;
    check_idle("t4_cap");
    step(); resp_lat = 1; #1;
    check_req("t4_new", 32'h8000_0100);

    // Test 5a: flush together with the response
    step(); flush = 1'b1; target = 32'h8000_0200; #1;
    check("t5a_resp", {63'd0, bus.imem_resp_valid}, 64'd1);
    check("t5a_pce", {63'd0, pc_enable}, 64'd1);
    step(); flush = 1'b0; #1;
    check_idle("t5a_drop");
    step(); #1;
    check_req("t5a_new", 32'h8000_0200);
    step(); #1;
    step(); #1;
    check_hold("t5a_hold", 32'h0200_0013, 32'h8000_0200, 1'b0);

    // Test 5b: flush beats inst_ready in HOLD
    flush = 1'b1; bus.inst_ready = 1'b1; target = 32'h8000_0300; #1;
    check("t5b_pce", {63'd0, pc_enable}, 64'd1);
    step(); flush = 1'b0; bus.inst_ready = 1'b0; #1;
    check_idle("t5b_cap");
    check("t5b_pce_cap", {63'd0, pc_enable}, 64'd0);
    step(); #1;
    check_req("t5b_new", 32'h8000_0300);
    step(); #1;
    step(); #1;
    check_hold("t5b_hold", 32'h0300_0013, 32'h8000_0300, 1'b0);
    bus.inst_ready = 1'b1;

    // Flush in CAPTURE: address resampled one cycle later
    step(); bus.inst_ready = 1'b0; flush = 1'b1; target = 32'h8000_0500; #1;
    check("cap_pce", {63'd0, pc_enable}, 64'd1);
    step(); flush = 1'b0; #1;
    check_idle("cap_again");
    step(); #1;
    check_req("cap_new", 32'h8000_0500);

    // Repeated flushes while kill is set: request kept, one response dropped
    bus.imem_req_ready = 1'b0; flush = 1'b1; target = 32'h8000_0600;
    step(); bus.imem_req_ready = 1'b1; target = 32'h8000_0700; #1;
    check_req("rep_keep", 32'h8000_0500);
    step(); flush = 1'b0; #1;
    check("rep_resp", {63'd0, bus.imem_resp_valid}, 64'd1);
    check_idle("rep_drop");
    step(); #1;
    check_idle("rep_cap");
    step(); #1;
    check_req("rep_new", 32'h8000_0700);
    step(); #1;
    step(); #1;
    check_hold("rep_hold", 32'h0700_0013, 32'h8000_0700, 1'b0);
    bus.inst_ready = 1'b1;

    // Test 6b: asynchronous reset in WAIT
    step(); bus.inst_ready = 1'b0; #1;
    step(); resp_lat = 3; #1;
    check_req("t6b_req", 32'h8000_0704);
    step(); #1;
    rst = 1'b0; #1;
    check_idle("t6b_rst");
    check("t6b_pce", {63'd0, pc_enable}, 64'd0);
    check("t6b_inst", {32'd0, bus.inst}, 64'd0);
    check("t6b_ipc", {32'd0, bus.inst_pc}, 64'd0);
    check("t6b_ierr", {63'd0, bus.inst_err}, 64'd0);
    step(); resp_lat = 1; rst = 1'b1; #1;
    check_idle("t6b_c0");
    step(); #1;
    check_req("t6b_c1", 32'h8000_0000);
    step(); #1;
    step(); #1;
    check_hold("t6b_c3", 32'h0000_0413, 32'h8000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC generator. Consumes the current PC and issues one instruction-memory read per PC over a valid/ready request channel.
- Registers the returned instruction and presents it to decode with a valid/ready handshake.
- Drives the PC generator's enable so the PC advances only when decode has taken an instruction or a redirect occurs. A redirect that lands while a read is in flight discards that read.

Parameters:
- PC_WIDTH, 32, width of PC and memory address.
- INST_WIDTH, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- pc  input  PC_WIDTH  current PC from the PC generator.
- flush  input  1  redirect. The PC generator loads the branch target on the same edge that this block sees flush.
- pc_enable  output  1  advance or load enable to the PC generator.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  PC_WIDTH  read address.
- imem_resp_valid  input  1  read data valid. Memory never responds in the same cycle it accepts a request.
- imem_resp_data  input  INST_WIDTH  read data.
- imem_resp_err  input  1  access fault for this response.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  INST_WIDTH  fetched instruction.
- inst_pc  output  PC_WIDTH  PC of the fetched instruction.
- inst_err  output  1  fetch access fault flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CAPTURE, kill=0.
  - req_addr_q, inst, inst_pc, inst_err = 0.
  - inst_valid=0, imem_req_valid=0, pc_enable=0.
- States: CAPTURE, REQ, WAIT, HOLD.
- CAPTURE:
  - req_addr_q<=pc, then go to REQ.
  - This one-cycle slot lets the PC generator update after pc_enable.
- REQ:
  - imem_req_valid=1 and imem_req_addr=req_addr_q; both held stable until accepted.
  - On valid&ready, go to WAIT.
- WAIT, on imem_resp_valid:
  - If kill=0: inst<=resp_data, inst_err<=resp_err, inst_pc<=req_addr_q, go to HOLD.
  - If kill=1: discard the response, clear kill, go to CAPTURE.
- HOLD:
  - inst_valid=1; inst, inst_pc and inst_err held stable.
  - On inst_valid&inst_ready, go to CAPTURE.
- pc_enable is combinational: pc_enable = flush | (HOLD & inst_ready).
- Flush handling, by state:
  - HOLD: inst_valid drops the next cycle with no handshake, go to CAPTURE. Flush has priority over inst_ready in the same cycle; pc_enable=1 either way.
  - REQ (accepted or not): the request is not withdrawn. Set kill=1; normal REQ→WAIT progression continues.
  - WAIT without resp_valid: set kill=1.
  - WAIT with resp_valid in the same cycle: discard the data, go to CAPTURE, kill stays 0.
  - CAPTURE: stay on the CAPTURE→REQ path. The address is sampled after the PC generator updates, so it is sampled on the next CAPTURE cycle: go to CAPTURE again, not REQ.
  - Repeated flushes while kill=1: kill stays 1; only one response is dropped.
- Nominal timing with a zero-wait memory:
  - CAPTURE at cycle 0, request accepted at cycle 1, response at cycle 2, inst_valid from cycle 3.
  - Throughput is one instruction per 4 cycles.
- At most one outstanding memory request.
- inst_valid and imem_req_valid are never both 1.
- Asynchronous reset mid-transaction returns to CAPTURE with kill=0. Any late memory response after reset is the memory's responsibility and is not tracked.
- Addresses are used as given: no alignment check and no wrap handling beyond PC_WIDTH.

Test Plan:
1. Reset release with pc=0x8000_0000, memory ready=1 and 1-cycle response data 0x0000_0413 → cycle 1 shows req_valid=1 and addr=0x8000_0000; cycle 3 shows inst_valid=1, inst=0x0000_0413, inst_pc=0x8000_0000, inst_err=0.
2. inst_ready held 0 for 5 cycles in HOLD, then 1 → inst stays stable and pc_enable=0 throughout the stall; pc_enable=1 exactly in the accept cycle; next request goes to 0x8000_0004.
3. imem_req_ready=0 for 3 cycles → req_valid and addr=0x8000_0004 stay constant until accepted.
4. flush during WAIT (target 0x8000_0100), response arrives 2 cycles later → response dropped, no inst_valid; the next request is to 0x8000_0100.
5. flush in the same cycle as imem_resp_valid, and separately flush with inst_ready=1 in HOLD → no instruction delivered, kill=0, the next request is to the flush target, pc_enable=1 once.
6. imem_resp_err=1 on fetch at 0x8000_0008 → inst_valid=1, inst_err=1, inst_pc=0x8000_0008; reset asserted in WAIT → all outputs 0 immediately, no clock edge needed.
